// File: rtl/dshot_pkg.sv
// dshot_pkg: shared DSHOT types, bit timing and CRC helpers.
// Define DSHOT_BIDIR_EN for inverted (bidirectional) line polarity and CRC.
package dshot_pkg;
`ifdef DSHOT_BIDIR_EN
  localparam logic BIDIR = 1'b1;
`else
  localparam logic BIDIR = 1'b0;
`endif
  typedef enum logic [1:0] {DSHOT150 = 2'd0, DSHOT300 = 2'd1, DSHOT600 = 2'd2} dshot_mode_e;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_BIT, S_GAP} dshot_state_e;
  function automatic int unsigned dshot_period(int unsigned clk_hz, dshot_mode_e m);
    return clk_hz / (32'd150000 << m);
  endfunction
  function automatic int unsigned dshot_cnt_w(int unsigned clk_hz, int unsigned idle_bits);
    return $clog2(idle_bits * dshot_period(clk_hz, DSHOT150));
  endfunction
  function automatic logic [3:0] dshot_crc(logic [11:0] v);
    return v[3:0] ^ v[7:4] ^ v[11:8] ^ {4{BIDIR}};
  endfunction
endpackage

// File: rtl/dshot_multi_tx_bit_timer.sv
// dshot_bit_timer: shared LOAD/BIT/GAP sequencer with cycle and bit counters for all channels.
module dshot_bit_timer
  import dshot_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 72_000_000,
  parameter int unsigned IDLE_BITS = 4,
  parameter int unsigned CW        = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    mode,
  output dshot_state_e  state,
  output logic [CW-1:0] cyc,
  output logic [CW-1:0] t0h,
  output logic [CW-1:0] t1h,
  output logic          bit_tick,
  output logic          frame_done,
  output logic          busy
);
  localparam int unsigned P1 = dshot_period(CLK_HZ, DSHOT150);
  localparam int unsigned P3 = dshot_period(CLK_HZ, DSHOT300);
  localparam int unsigned P6 = dshot_period(CLK_HZ, DSHOT600);
  localparam logic [CW-1:0] LAST [3] = '{CW'(P1 - 1), CW'(P3 - 1), CW'(P6 - 1)};
  localparam logic [CW-1:0] H0 [3] = '{CW'(P1 * 3 / 8), CW'(P3 * 3 / 8), CW'(P6 * 3 / 8)};
  localparam logic [CW-1:0] H1 [3] = '{CW'(P1 * 3 / 4), CW'(P3 * 3 / 4), CW'(P6 * 3 / 4)};
  // LOAD also drives the line idle, so GAP is one cycle short of IDLE_BITS*T
  localparam logic [CW-1:0] GLAST [3] = '{CW'(IDLE_BITS * P1 - 2), CW'(IDLE_BITS * P3 - 2), CW'(IDLE_BITS * P6 - 2)};
  dshot_state_e state_n;
  dshot_mode_e m_q;
  logic [CW-1:0] cyc_n;
  logic [3:0] bit_q, bit_n;
  assign t0h = H0[m_q];
  assign t1h = H1[m_q];
  assign bit_tick = (state == S_BIT) && (cyc == LAST[m_q]);
  assign frame_done = (state == S_GAP) && (cyc == '0);
  assign busy = (state == S_LOAD) || (state == S_BIT);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cyc   <= '0;
      bit_q <= '0;
      m_q   <= DSHOT150;
    end else begin
      state <= state_n;
      cyc   <= cyc_n;
      bit_q <= bit_n;
      if (state == S_LOAD) m_q <= (mode == 2'd3) ? DSHOT150 : dshot_mode_e'(mode);
    end
  end
  always_comb begin
    state_n = state;
    cyc_n   = cyc;
    bit_n   = bit_q;
    case (state)
      S_IDLE: state_n = start ? S_LOAD : S_IDLE;
      S_LOAD: begin
        state_n = S_BIT;
        cyc_n   = '0;
        bit_n   = 4'd15;
      end
      S_BIT: begin
        cyc_n   = bit_tick ? '0 : cyc + 1'b1;
        bit_n   = bit_tick ? bit_q - 1'b1 : bit_q;
        state_n = (bit_tick && bit_q == 4'd0) ? S_GAP : S_BIT;
      end
      S_GAP: begin
        cyc_n   = (cyc == GLAST[m_q]) ? '0 : cyc + 1'b1;
        state_n = (cyc == GLAST[m_q]) ? S_LOAD : S_GAP;
      end
      default: state_n = S_IDLE;
    endcase
  end
endmodule

// File: rtl/dshot_multi_tx.sv
// dshot_multi_tx: N-channel DSHOT150/300/600 transmitter with shadowed throttle words.
// Define DSHOT_BIDIR_EN for bidirectional framing (idle-high line, inverted CRC).
module dshot_multi_tx
  import dshot_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 72_000_000,
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned IDLE_BITS = 4,
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [1:0]        i_mode,
  input  logic              i_wr_en,
  input  logic [CHW-1:0]    i_wr_ch,
  input  logic [11:0]       i_wr_data,
  output logic [NUM_CH-1:0] o_motor,
  output logic              o_frame_done,
  output logic              o_busy
);
  localparam int unsigned CW = dshot_cnt_w(CLK_HZ, IDLE_BITS);
  dshot_state_e state;
  logic [CW-1:0] cyc, t0h, t1h;
  logic bit_tick;
  logic [11:0] shadow [NUM_CH];
  logic [15:0] sh [NUM_CH];
  logic [NUM_CH-1:0] valid, act;
  logic wr_ok;
  assign wr_ok = i_wr_en && (int'(i_wr_ch) < int'(NUM_CH));
  dshot_bit_timer #(.CLK_HZ(CLK_HZ), .IDLE_BITS(IDLE_BITS), .CW(CW)) u_timer (
    .clk        (i_clk),
    .rst        (i_rst),
    .start      (|valid),
    .mode       (i_mode),
    .state      (state),
    .cyc        (cyc),
    .t0h        (t0h),
    .t1h        (t1h),
    .bit_tick   (bit_tick),
    .frame_done (o_frame_done),
    .busy       (o_busy)
  );
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid <= '0;
      act   <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        shadow[c] <= '0;
        sh[c]     <= '0;
      end
    end else begin
      if (wr_ok) begin
        shadow[i_wr_ch] <= i_wr_data;
        valid[i_wr_ch]  <= 1'b1;
      end
      // LOAD sees pre-edge shadows, so a same-cycle write lands in the next frame
      if (state == S_LOAD) act <= valid;
      for (int c = 0; c < NUM_CH; c++)
        if (state == S_LOAD) sh[c] <= {shadow[c], dshot_crc(shadow[c])};
        else if (bit_tick) sh[c] <= {sh[c][14:0], 1'b0};
    end
  end
  always_comb begin
    o_motor = {NUM_CH{BIDIR}};
    for (int c = 0; c < NUM_CH; c++)
      o_motor[c] = BIDIR ^ ((state == S_BIT) && act[c] && (cyc < (sh[c][15] ? t1h : t0h)));
  end
endmodule

// File: tb/tb_dshot_multi_tx.sv
// tb_dshot_multi_tx: scoreboard bench decoding every channel's line into frames and timing.
module tb_dshot_multi_tx;
  localparam int NCH = 3;
`ifdef DSHOT_BIDIR_EN
  localparam logic IDLE = 1'b1;
`else
  localparam logic IDLE = 1'b0;
`endif
  localparam logic [NCH-1:0] IDLE_ALL = {NCH{IDLE}};
  typedef struct packed {
    logic [NCH-1:0]       act;
    logic [NCH-1:0][15:0] w;
    logic [9:0]           t;
    logic                 cp;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, wr_en = 1'b0, frame_done, busy;
  logic [1:0] mode = 2'd0, wr_ch = 2'd0;
  logic [11:0] wr_data = '0;
  logic [NCH-1:0] motor;
  exp_t sb[$];
  exp_t rec;
  int n_checks = 0, n_err = 0, cyc = 0, last_fd = 0;
  int hlen[NCH], nb[NCH], lr[NCH];
  logic [15:0] wd[NCH];
  bit rs[NCH];
  int misal = 0, per_bad = 0, hi_bad = 0, tt;
  logic [NCH-1:0] a, pa = '0, r, f;

  dshot_multi_tx #(.CLK_HZ(72_000_000), .NUM_CH(NCH), .IDLE_BITS(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_mode(mode), .i_wr_en(wr_en), .i_wr_ch(wr_ch),
    .i_wr_data(wr_data), .o_motor(motor), .o_frame_done(frame_done), .o_busy(busy)
  );
  always #7 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] frm(logic [11:0] v);
    logic [3:0] c;
    c = v[3:0] ^ v[7:4] ^ v[11:8];
    return {v, c ^ {4{IDLE}}};
  endfunction

  task automatic push(logic [NCH-1:0] act, logic [11:0] v0, v1, v2, int m, bit cp);
    exp_t e;
    e.act = act;
    e.w[0] = frm(v0);
    e.w[1] = frm(v1);
    e.w[2] = frm(v2);
    e.t = 10'(72_000_000 / (150_000 << m));
    e.cp = cp;
    sb.push_back(e);
  endtask

  task automatic clr();
    for (int c = 0; c < NCH; c++) begin
      hlen[c] = 0; nb[c] = 0; wd[c] = '0; rs[c] = 0;
    end
    misal = 0; per_bad = 0; hi_bad = 0;
  endtask

  always @(negedge clk) begin
    a = motor ^ IDLE_ALL;
    if (rst) begin
      pa = '0;
      clr();
    end else begin
      r = a & ~pa;
      f = pa & ~a;
      tt = (sb.size() > 0) ? int'(sb[0].t) : 0;
      if (r != '0 && sb.size() > 0 && r != sb[0].act) misal++;
      for (int c = 0; c < NCH; c++) begin
        if (a[c]) hlen[c]++;
        if (r[c]) begin
          if (rs[c] && tt != 0 && cyc - lr[c] != tt) per_bad++;
          lr[c] = cyc;
          rs[c] = 1;
        end
        if (f[c]) begin
          if (tt != 0 && hlen[c] != tt * 3 / 8 && hlen[c] != tt * 3 / 4) hi_bad++;
          wd[c] = {wd[c][14:0], hlen[c] > (tt * 3 / 8 + tt * 3 / 4) / 2};
          nb[c]++;
          hlen[c] = 0;
        end
      end
      if (frame_done) begin
        if (sb.size() > 0) begin
          rec = sb.pop_front();
          for (int c = 0; c < NCH; c++)
            if (rec.act[c]) begin
              check($sformatf("bits_ch%0d", c), nb[c], 16);
              check($sformatf("word_ch%0d", c), wd[c], rec.w[c]);
            end else check($sformatf("quiet_ch%0d", c), nb[c], 0);
          check("misalign", misal, 0);
          check("bit_period", per_bad, 0);
          check("high_time", hi_bad, 0);
          check("gap_idle", motor, IDLE_ALL);
          if (rec.cp) check("frame_period", cyc - last_fd, 20 * int'(rec.t));
        end
        last_fd = cyc;
        clr();
      end
      pa = a;
    end
  end

  task automatic write(logic [1:0] ch, logic [11:0] d);
    wr_en = 1'b1; wr_ch = ch; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic drain(int budget);
    int k = 0;
    while (sb.size() > 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    check("sb_drain", sb.size(), 0);
    sb.delete();
  endtask

  task automatic wait_load(int budget);
    int k;
    logic pb;
    pb = busy;
    for (k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      if (busy && !pb) break;
      pb = busy;
    end
    check("load_seen", k < budget, 1);
  endtask

  initial begin
    int cnt;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_motor", motor, IDLE_ALL);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    // DSHOT150 single channel, then abort mid-frame
    mode = 2'd0;
    write(2'd0, 12'h060);
    push(3'b001, 12'h060, 0, 0, 0, 0);
    push(3'b001, 12'h060, 0, 0, 0, 1);
    drain(20000);
    wait_load(2000);
    repeat (8 * 480 + 240) @(posedge clk);
    #1 check("busy_mid", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_motor", motor, IDLE_ALL);
    check("abort_busy", busy, 0);
    write(2'd3, 12'hFFF);
    cnt = 0;
    repeat (600) begin
      @(posedge clk); #1;
      if (busy || frame_done || motor != IDLE_ALL) cnt++;
    end
    check("no_frame_after", cnt, 0);
    // DSHOT600 on channel 1
    do_reset();
    mode = 2'd2;
    write(2'd1, 12'h82D);
    push(3'b010, 0, 12'h82D, 0, 2, 0);
    push(3'b010, 0, 12'h82D, 0, 2, 1);
    drain(6000);
    // DSHOT300 on channels 0 and 2
    do_reset();
    mode = 2'd1;
    write(2'd0, 12'h123);
    write(2'd2, 12'hABC);
    push(3'b101, 12'h123, 0, 12'hABC, 1, 0);
    push(3'b101, 12'h123, 0, 12'hABC, 1, 1);
    push(3'b101, 12'h123, 0, 12'hABC, 1, 1);
    drain(16000);
    // shadow updates during BIT and in the exact LOAD cycle
    do_reset();
    mode = 2'd1;
    write(2'd0, 12'h111);
    push(3'b001, 12'h111, 0, 0, 1, 0);
    wait_load(100);
    repeat (100) @(posedge clk);
    #1 write(2'd0, 12'h222);
    push(3'b001, 12'h222, 0, 0, 1, 1);
    drain(11000);
    wait_load(2000);
    write(2'd0, 12'h333);
    push(3'b001, 12'h222, 0, 0, 1, 1);
    push(3'b001, 12'h333, 0, 0, 1, 1);
    drain(11000);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
